// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: decode reservation, hazard query, two writeback requesters
// and the registered register-file write port.
interface rf_wb_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;

    modport master (
        output iss_valid, iss_rd, rs1, rs2,
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  iss_ready, rs1_busy, rs2_busy, alu_ready, mem_ready,
        input  rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  iss_valid, iss_rd, rs1, rs2,
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output iss_ready, rs1_busy, rs2_busy, alu_ready, mem_ready,
        output rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with per-register busy scoreboard.
// Define RF_WB_FIXED_PRIO_EN for fixed MEM-over-ALU priority instead of round-robin.
module rf_wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    rf_wb_arbiter_if.slave    bus
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_wa_q, rf_wa_d;
    logic [XLEN-1:0] rf_wd_q, rf_wd_d;

    logic            iss_ready;
    logic            alu_gnt;
    logic            mem_gnt;
    logic            mem_pref;

    // Scoreboard reads are raw: a same-cycle clear does not make a register ready early.
    assign iss_ready    = ~busy_q[bus.iss_rd];
    assign bus.iss_ready = iss_ready;
    assign bus.rs1_busy  = busy_q[bus.rs1];
    assign bus.rs2_busy  = busy_q[bus.rs2];

`ifdef RF_WB_FIXED_PRIO_EN
    assign mem_pref = 1'b1;
`else
    logic rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (alu_gnt) begin
            rr_d = 1'b1;
        end else if (mem_gnt) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign mem_pref = rr_q;
`endif

    always_comb begin
        alu_gnt = bus.alu_valid & (~bus.mem_valid | ~mem_pref);
        mem_gnt = bus.mem_valid & (~bus.alu_valid | mem_pref);
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.mem_ready = mem_gnt;

    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_wa_q] = 1'b0;
        end
        if (bus.iss_valid && iss_ready && (bus.iss_rd != '0)) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Writes to x0 still complete the handshake but never reach the register file.
    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (alu_gnt) begin
            rf_we_d = (bus.alu_rd != '0);
            rf_wa_d = bus.alu_rd;
            rf_wd_d = bus.alu_data;
        end else if (mem_gnt) begin
            rf_we_d = (bus.mem_rd != '0);
            rf_wa_d = bus.mem_rd;
            rf_wd_d = bus.mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else begin
            busy_q  <= busy_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign bus.rf_we = rf_we_q;
    assign bus.rf_wa = rf_wa_q;
    assign bus.rf_wd = rf_wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

`ifdef RF_WB_FIXED_PRIO_EN
    localparam bit Fixed = 1'b1;
`else
    localparam bit Fixed = 1'b0;
`endif

    logic clk;
    logic rst_n;

    rf_wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

    rf_wb_arbiter #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    task automatic issue(input logic [4:0] rd);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = rd;
        #1;
        check("issue_ready", bus.iss_ready, 1);
        step();
        bus.iss_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        step();

        // Reset: busy[5] set and a grant in flight, then asynchronous reset mid-cycle
        issue(5'd5);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hCAFE_0005;
        step();
        bus.alu_valid = 1'b0;
        bus.rs1       = 5'd5;
        #1;
        check("rst_pre_we", bus.rf_we, 1);
        check("rst_pre_busy5", bus.rs1_busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_we", bus.rf_we, 0);
        check("rst_wa", bus.rf_wa, 0);
        check("rst_wd", bus.rf_wd, 0);
        check("rst_busy5", bus.rs1_busy, 0);
        #1;
        rst_n = 1'b1;
        step();
        bus.iss_rd = 5'd5;
        #1;
        check("rst_iss5_ready", bus.iss_ready, 1);

        // Single ALU write
        do_reset();
        issue(5'd7);
        bus.rs1       = 5'd7;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd7;
        bus.alu_data  = 32'hDEAD_BEEF;
        #1;
        check("alu_ready", bus.alu_ready, 1);
        check("alu_mem_ready", bus.mem_ready, 0);
        check("alu_busy_pend", bus.rs1_busy, 1);
        step();
        bus.alu_valid = 1'b0;
        #1;
        check("alu_we", bus.rf_we, 1);
        check("alu_wa", bus.rf_wa, 7);
        check("alu_wd", bus.rf_wd, 32'hDEAD_BEEF);
        check("alu_busy_wcyc", bus.rs1_busy, 1);
        step();
        check("alu_we_after", bus.rf_we, 0);
        check("alu_busy_clr", bus.rs1_busy, 0);
        check("alu_wd_hold", bus.rf_wd, 32'hDEAD_BEEF);

        // Contention from reset
        do_reset();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'h11;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd4;
        bus.mem_data  = 32'h22;
        #1;
        check("cont0_alu_ready", bus.alu_ready, !Fixed);
        check("cont0_mem_ready", bus.mem_ready, Fixed);
        step();
        if (Fixed) bus.mem_valid = 1'b0;
        else bus.alu_valid = 1'b0;
        #1;
        check("cont1_alu_ready", bus.alu_ready, Fixed);
        check("cont1_mem_ready", bus.mem_ready, !Fixed);
        check("cont1_we", bus.rf_we, 1);
        check("cont1_wa", bus.rf_wa, Fixed ? 4 : 3);
        check("cont1_wd", bus.rf_wd, Fixed ? 32'h22 : 32'h11);
        step();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        check("cont2_we", bus.rf_we, 1);
        check("cont2_wa", bus.rf_wa, Fixed ? 3 : 4);
        check("cont2_wd", bus.rf_wd, Fixed ? 32'h11 : 32'h22);
        step();
        check("cont3_we", bus.rf_we, 0);

        // WAW stall on register 9
        do_reset();
        issue(5'd9);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        #1;
        check("waw_stall0", bus.iss_ready, 0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_data  = 32'h99;
        #1;
        check("waw_alu_ready", bus.alu_ready, 1);
        step();
        bus.alu_valid = 1'b0;
        #1;
        check("waw_we", bus.rf_we, 1);
        check("waw_wa", bus.rf_wa, 9);
        check("waw_stall_wcyc", bus.iss_ready, 0);
        step();
        check("waw_ready_after", bus.iss_ready, 1);
        bus.iss_valid = 1'b0;

        // x0 handling
        do_reset();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        #1;
        check("x0_iss_ready", bus.iss_ready, 1);
        step();
        bus.iss_valid = 1'b0;
        bus.rs1       = 5'd0;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd0;
        bus.mem_data  = 32'hFFFF_FFFF;
        #1;
        check("x0_busy", bus.rs1_busy, 0);
        check("x0_mem_ready", bus.mem_ready, 1);
        step();
        bus.mem_valid = 1'b0;
        check("x0_we", bus.rf_we, 0);
        step();
        check("x0_we_later", bus.rf_we, 0);

        // Back-to-back ALU writes to 1..4
        do_reset();
        for (int k = 1; k <= 4; k++) issue(5'(k));
        bus.alu_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.alu_rd   = 5'(k);
            bus.alu_data = 32'(k * 32'h100);
            #1;
            check("b2b_ready", bus.alu_ready, 1);
            step();
            check("b2b_we", bus.rf_we, 1);
            check("b2b_wa", bus.rf_wa, k);
            check("b2b_wd", bus.rf_wd, k * 32'h100);
            bus.rs1 = 5'(k);
            bus.rs2 = 5'(k - 1);
            #1;
            check("b2b_busy_cur", bus.rs1_busy, 1);
            check("b2b_busy_prev", bus.rs2_busy, (k == 1) ? 0 : 0);
        end
        bus.alu_valid = 1'b0;
        step();
        check("b2b_we_end", bus.rf_we, 0);
        check("b2b_busy4_clr", bus.rs1_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
